// File: rtl/delay_meas_pkg.sv
// Shared types and constants for the delay_meas cell-chain delay measurement block.
package delay_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH_R,
        WAIT_R,
        LAUNCH_F,
        WAIT_F,
        REPORT
    } state_t;

    // Synchronizer adds this many extra counts beyond the true flop delay of the chain.
    localparam int SYNC_LAT = 1;

endpackage

// File: rtl/delay_meas_sync.sv
// Two-flop synchronizer bringing the asynchronous chain output into the clk domain.
module delay_meas_sync (
    input  logic clk,
    input  logic r,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (r) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/delay_meas.sv
// Measures rise/fall propagation delay of a cell chain, averaged over 2^AVG_LOG2 pairs.
// Optional timeout compiled in with DELAY_MEAS_TIMEOUT_EN.
module delay_meas
    import delay_meas_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 3,
    parameter int TMO      = 1000
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    output logic             launch,
    input  logic             sense,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] rise_dly,
    output logic [CNT_W-1:0] fall_dly,
    output logic             err
);

    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int NPAIRS = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] LAST_PAIR = (AVG_LOG2 + 1)'(NPAIRS - 1);
    localparam logic [CNT_W-1:0]  LAT       = CNT_W'(SYNC_LAT);

    if (TMO < 1 || longint'(TMO) >= (longint'(1) << CNT_W)) begin : g_bad_tmo
        $error("delay_meas: TMO must fit the cycle counter");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [AVG_LOG2:0] pair_cnt;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_f;
    logic [ACC_W-1:0]  acc_f_sum;
    logic [CNT_W-1:0]  smp;
    logic              sense_s;
    logic              tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sample_of(input logic [CNT_W-1:0] c);
        return (c >= LAT) ? c - LAT : '0;
    endfunction

    delay_meas_sync u_sync (
        .clk (clk),
        .r   (r),
        .d   (sense),
        .q   (sense_s)
    );

`ifdef DELAY_MEAS_TIMEOUT_EN
    assign tmo_hit = (cnt == CNT_W'(TMO));
`else
    assign tmo_hit = 1'b0;
`endif

    assign smp       = sample_of(cnt);
    assign acc_f_sum = acc_f + ACC_W'(smp);

    always_ff @(posedge clk) begin
        if (r) begin
            state     <= IDLE;
            launch    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            rise_dly  <= '0;
            fall_dly  <= '0;
            cnt       <= '0;
            pair_cnt  <= '0;
            acc_r     <= '0;
            acc_f     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LAUNCH_R;
                        launch   <= 1'b1;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        pair_cnt <= '0;
                        acc_r    <= '0;
                        acc_f    <= '0;
                    end
                end
                LAUNCH_R: begin
                    cnt   <= '0;
                    state <= WAIT_R;
                end
                WAIT_R: begin
                    if (sense_s) begin
                        acc_r  <= acc_r + ACC_W'(smp);
                        launch <= 1'b0;
                        state  <= LAUNCH_F;
                    end else if (tmo_hit) begin
                        err       <= 1'b1;
                        rise_dly  <= '1;
                        fall_dly  <= '1;
                        launch    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                LAUNCH_F: begin
                    cnt   <= '0;
                    state <= WAIT_F;
                end
                WAIT_F: begin
                    if (!sense_s) begin
                        if (pair_cnt == LAST_PAIR) begin
                            rise_dly  <= CNT_W'(acc_r >> AVG_LOG2);
                            fall_dly  <= CNT_W'(acc_f_sum >> AVG_LOG2);
                            res_valid <= 1'b1;
                            state     <= REPORT;
                        end else begin
                            acc_f    <= acc_f_sum;
                            pair_cnt <= pair_cnt + 1'b1;
                            launch   <= 1'b1;
                            state    <= LAUNCH_R;
                        end
                    end else if (tmo_hit) begin
                        err       <= 1'b1;
                        rise_dly  <= '1;
                        fall_dly  <= '1;
                        launch    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_meas.sv
// Self-checking bench for delay_meas: a behavioural delay line drives sense from launch.
module tb_delay_meas;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             r = 1'b1;
    logic             start = 1'b0;
    logic             launch;
    logic             sense;
    logic             busy;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [CNT_W-1:0] rise_dly;
    logic [CNT_W-1:0] fall_dly;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    // Delay line model: per-pair rising delay, one falling delay, optional stuck-at-0.
    int         rd_arr [8];
    int         fd_cur = 0;
    logic       force0 = 1'b0;
    logic       fc_clr = 1'b0;
    logic [15:0] hq = '0;
    logic       lq = 1'b0;
    int         fc = 0;

    typedef struct {
        string name;
        int    rd_a;
        int    rd_b;
        int    n_b;
        int    fd;
        int    exp_r;
        int    exp_f;
    } vec_t;

    vec_t vecs [6];

    delay_meas #(.CNT_W(CNT_W), .AVG_LOG2(3), .TMO(100)) dut (
        .clk       (clk),
        .r         (r),
        .start     (start),
        .launch    (launch),
        .sense     (sense),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .rise_dly  (rise_dly),
        .fall_dly  (fall_dly),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hq <= {hq[14:0], launch};
        lq <= launch;
        if (fc_clr)
            fc <= 0;
        else if (lq && !launch)
            fc <= fc + 1;
    end

    always_comb begin
        int d;
        d = launch ? rd_arr[fc & 7] : fd_cur;
        if (force0)
            sense = 1'b0;
        else if (d == 0)
            sense = launch;
        else
            sense = hq[d-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int budget;
        budget = 0;
        while (res_valid !== 1'b1 && budget < limit) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_valid"}, res_valid, 1);
    endtask

    task automatic begin_run();
        fc_clr = 1'b1;
        @(negedge clk);
        fc_clr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input string tag, input int exp_r, input int exp_f);
        begin_run();
        check({tag, "_busy"}, busy, 1);
        wait_valid(tag, 3000);
        check({tag, "_rise"}, rise_dly, exp_r);
        check({tag, "_fall"}, fall_dly, exp_f);
        check({tag, "_err"}, err, 0);
        check({tag, "_launch"}, launch, 0);
        check({tag, "_pairs"}, fc, 8);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle"}, busy, 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int sum;
        int fd;
        vecs[0] = '{"d5",      5, 5, 0, 5, 5, 5};
        vecs[1] = '{"r3x7_4",  3, 4, 1, 3, 3, 3};
        vecs[2] = '{"zero",    0, 0, 0, 0, 0, 0};
        vecs[3] = '{"r2_1",    2, 1, 4, 2, 1, 2};
        vecs[4] = '{"r6_7",    6, 7, 3, 6, 6, 6};
        vecs[5] = '{"r1_3",    1, 3, 7, 2, 2, 2};
        foreach (rd_arr[p]) rd_arr[p] = 0;

        repeat (3) @(negedge clk);
        check("rst_launch", launch, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_err", err, 0);
        check("rst_rise", rise_dly, 0);
        check("rst_fall", fall_dly, 0);
        // reset wins over simultaneous start
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r = 1'b0;
        check("rst_over_start", busy, 0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 8; p++)
                rd_arr[p] = (p < 8 - vecs[i].n_b) ? vecs[i].rd_a : vecs[i].rd_b;
            fd_cur = vecs[i].fd;
            do_run(vecs[i].name, vecs[i].exp_r, vecs[i].exp_f);
        end

        for (int k = 0; k < 6; k++) begin
            fd = int'($urandom_range(2, 8));
            sum = 0;
            for (int p = 0; p < 8; p++) begin
                rd_arr[p] = fd - 2 + int'($urandom_range(0, 4));
                sum += rd_arr[p];
            end
            fd_cur = fd;
            do_run($sformatf("rand%0d", k), sum / 8, fd);
        end

        // result held while res_ready stays low, start pulses ignored
        for (int p = 0; p < 8; p++) rd_arr[p] = 5;
        fd_cur = 5;
        begin_run();
        wait_valid("hold", 3000);
        for (int k = 0; k < 20; k++) begin
            start = (k % 3 == 0);
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_rise", rise_dly, 5);
            check("hold_launch", launch, 0);
        end
        start = 1'b0;
        check("hold_fall", fall_dly, 5);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("hold_done_valid", res_valid, 0);
        check("hold_done_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("idle_keep_rise", rise_dly, 5);
        check("idle_keep_fall", fall_dly, 5);
        check("idle_no_launch", launch, 0);
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
        check("ready_in_idle", busy, 0);
        repeat (10) @(negedge clk);

        // reset during WAIT_F aborts the measurement
        begin_run();
        begin
            int budget;
            budget = 0;
            while (fc < 1 && budget < 500) begin
                @(negedge clk);
                budget++;
            end
        end
        check("abort_reached_wf", fc, 1);
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        check("abort_launch", launch, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_rise", rise_dly, 0);
        repeat (20) @(negedge clk);
        do_run("after_abort", 5, 5);

        // sense stuck low
        force0 = 1'b1;
        begin_run();
`ifdef DELAY_MEAS_TIMEOUT_EN
        wait_valid("tmo", 104);
        check("tmo_err", err, 1);
        check("tmo_rise", rise_dly, 32'hFFFF);
        check("tmo_fall", fall_dly, 32'hFFFF);
        check("tmo_launch", launch, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("tmo_idle", busy, 0);
`else
        repeat (300) @(negedge clk);
        check("stuck_valid", res_valid, 0);
        check("stuck_busy", busy, 1);
        check("stuck_launch", launch, 1);
        check("stuck_err", err, 0);
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        check("stuck_rst_busy", busy, 0);
`endif
        force0 = 1'b0;
        repeat (20) @(negedge clk);
        do_run("final", 5, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
